// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_arb_pkg -- FSM state type and default geometry for the frame arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int ADDR_W_DEF      = 24;
  localparam int DATA_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int FB_BASE_DEF     = 0;
  localparam int FRAME_WORDS_DEF = 76800;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_WR_WAIT  = 3'd4
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo_fwft -- single-clock first-word-fall-through FIFO with flush
// Revision: 1.0
// ----------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             underflow_q, underflow_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok     = push && (level_q != LW'(DEPTH));
    pop_ok      = pop && (level_q != '0);
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q || (pop && (level_q == '0));
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout      = mem_q[rd_ptr_q];
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: rtl/sdram_frame_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_frame_arbiter -- shares one SDRAM controller port between display
//                        frame fetch (sequential reads) and loader writes
// Revision: 1.0
// ----------------------------------------------------------------------------
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int FB_BASE     = FB_BASE_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic                          mem_clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          fifo_rd_en,
  output logic [DATA_W-1:0]             fifo_dout,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic [ADDR_W-1:0]             ctl_rd_addr,
  output logic [ADDR_W-1:0]             ctl_wr_addr,
  output logic [DATA_W-1:0]             ctl_wr_data,
  output logic                          ctl_rd_enable,
  output logic                          ctl_wr_enable,
  input  logic [DATA_W-1:0]             ctl_rd_data,
  input  logic                          ctl_rd_ready,
  input  logic                          ctl_busy
);

  localparam int                 LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0]  FB_FIRST = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0]  FB_LAST  = ADDR_W'(FB_BASE + FRAME_WORDS - 1);

  arb_state_t          state_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic                frame_active_q;
  logic                drop_q;
  logic                wr_seen_busy_q;
  logic                wr_ready_q;
  logic                ctl_rd_enable_q;
  logic                ctl_wr_enable_q;
  logic [ADDR_W-1:0]   ctl_rd_addr_q;
  logic [ADDR_W-1:0]   ctl_wr_addr_q;
  logic [DATA_W-1:0]   ctl_wr_data_q;

  logic                rd_eligible;
  logic                rd_urgent;
  logic                fifo_push;
  logic [LVL_W-1:0]    level;

  always_comb begin
    rd_eligible = frame_active_q && (level < LVL_W'(FIFO_DEPTH));
    rd_urgent   = (level < LVL_W'(FIFO_DEPTH / 2));
    fifo_push   = (state_q == ST_RD_WAIT) && ctl_rd_ready && !drop_q && !frame_start;
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rd_ptr_q        <= FB_FIRST;
      frame_active_q  <= 1'b1;
      drop_q          <= 1'b0;
      wr_seen_busy_q  <= 1'b0;
      wr_ready_q      <= 1'b0;
      ctl_rd_enable_q <= 1'b0;
      ctl_wr_enable_q <= 1'b0;
      ctl_rd_addr_q   <= '0;
      ctl_wr_addr_q   <= '0;
      ctl_wr_data_q   <= '0;
    end else begin
      wr_ready_q      <= 1'b0;
      ctl_rd_enable_q <= 1'b0;
      ctl_wr_enable_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!ctl_busy) begin
            if (rd_eligible && (rd_urgent || !wr_valid)) begin
              // A restart in the decision cycle must fetch the new frame's first word.
              ctl_rd_addr_q <= frame_start ? FB_FIRST : rd_ptr_q;
              state_q       <= ST_RD_ISSUE;
            end else if (wr_valid) begin
              wr_ready_q    <= 1'b1;
              ctl_wr_addr_q <= wr_addr;
              ctl_wr_data_q <= wr_data;
              state_q       <= ST_WR_ISSUE;
            end
          end
        end
        ST_RD_ISSUE: begin
          if (!ctl_busy) begin
            ctl_rd_enable_q <= 1'b1;
            state_q         <= ST_RD_WAIT;
            if ((ctl_rd_addr_q == FB_LAST) && !drop_q && !frame_start) begin
              frame_active_q <= 1'b0;
            end
          end
        end
        ST_RD_WAIT: begin
          if (ctl_rd_ready) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
            if (!drop_q && !frame_start) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
          end
        end
        ST_WR_ISSUE: begin
          if (!ctl_busy) begin
            ctl_wr_enable_q <= 1'b1;
            wr_seen_busy_q  <= 1'b0;
            state_q         <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (ctl_busy) begin
            wr_seen_busy_q <= 1'b1;
          end else if (wr_seen_busy_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Restart overrides the sequencing above; a read still owed by the controller is discarded.
      if (frame_start) begin
        rd_ptr_q       <= FB_FIRST;
        frame_active_q <= 1'b1;
        if ((state_q == ST_RD_ISSUE) || ((state_q == ST_RD_WAIT) && !ctl_rd_ready)) begin
          drop_q <= 1'b1;
        end
      end
    end
  end

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fetch_fifo (
    .clk       (mem_clk),
    .rst       (rst),
    .flush     (frame_start),
    .push      (fifo_push),
    .din       (ctl_rd_data),
    .pop       (fifo_rd_en),
    .dout      (fifo_dout),
    .empty     (fifo_empty),
    .level     (level),
    .underflow (underflow)
  );

  assign fifo_level    = level;
  assign wr_ready      = wr_ready_q;
  assign ctl_rd_enable = ctl_rd_enable_q;
  assign ctl_wr_enable = ctl_wr_enable_q;
  assign ctl_rd_addr   = ctl_rd_addr_q;
  assign ctl_wr_addr   = ctl_wr_addr_q;
  assign ctl_wr_data   = ctl_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_frame_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sdram_frame_arbiter -- scoreboard bench with a behavioural SDRAM controller
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sdram_frame_arbiter;

  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int FW    = 24;

  logic          clk = 1'b0;
  logic          rst, frame_start, fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic [4:0]    fifo_level;
  logic          underflow;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] ctl_rd_addr, ctl_wr_addr;
  logic [DW-1:0] ctl_wr_data;
  logic          ctl_rd_enable, ctl_wr_enable;
  logic [DW-1:0] ctl_rd_data;
  logic          ctl_rd_ready, ctl_busy;

  always #5 clk = ~clk;

  sdram_frame_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FB_BASE(0), .FRAME_WORDS(FW)
  ) dut (
    .mem_clk(clk), .rst(rst), .frame_start(frame_start), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .underflow(underflow), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .ctl_rd_addr(ctl_rd_addr), .ctl_wr_addr(ctl_wr_addr),
    .ctl_wr_data(ctl_wr_data), .ctl_rd_enable(ctl_rd_enable), .ctl_wr_enable(ctl_wr_enable),
    .ctl_rd_data(ctl_rd_data), .ctl_rd_ready(ctl_rd_ready), .ctl_busy(ctl_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hC3A5;
  endfunction

  // Controller model state and scoreboards
  logic [DW-1:0] exp_q[$];
  logic [39:0]   wr_q[$];
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] pend_data, pend_exp;
  logic          force_busy;
  bit            fs_since_issue = 0;
  int            rd_timer = 0, wr_timer = 0;
  int            rd_issues = 0, wr_issues = 0, busy_viol = 0;

  initial begin
    ctl_rd_ready = 1'b0;
    ctl_rd_data  = '0;
    ctl_busy     = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      ctl_rd_ready = 1'b0;
      if (rst) begin
        rd_timer = 0;
        wr_timer = 0;
        ctl_busy = 1'b0;
      end else begin
        if ((ctl_rd_enable || ctl_wr_enable) && ctl_busy) busy_viol++;
        if (rd_timer > 0) begin
          rd_timer--;
          if (rd_timer == 0) begin
            ctl_rd_ready = 1'b1;
            ctl_rd_data  = pend_data;
            if (!fs_since_issue && !frame_start) exp_q.push_back(pend_exp);
          end
        end
        if (wr_timer > 0) wr_timer--;
        if (ctl_rd_enable) begin
          rd_issues++;
          check("rd_addr", ctl_rd_addr, (exp_addr < FW) ? exp_addr : 24'hFFFFFF);
          pend_data      = word_of(ctl_rd_addr);
          pend_exp       = word_of(exp_addr);
          rd_timer       = 3;
          fs_since_issue = 0;
          exp_addr++;
        end
        if (ctl_wr_enable) begin
          logic [39:0] e;
          wr_issues++;
          if (wr_q.size() == 0) begin
            check("wr_unexpected", 1, 0);
          end else begin
            e = wr_q.pop_front();
            check("wr_addr", ctl_wr_addr, e[39:16]);
            check("wr_data", ctl_wr_data, e[15:0]);
          end
          wr_timer = 2;
        end
        if (frame_start) begin
          if (rd_timer > 0) fs_since_issue = 1;
          exp_addr = '0;
          exp_q.delete();
        end
        ctl_busy = force_busy || (rd_timer > 0) || (wr_timer > 0);
      end
    end
  end

  task automatic pop_word(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, fifo_dout, e);
    end
    check({tag, "_empty"}, fifo_empty, 0);
    fifo_rd_en = 1'b1;
    @(negedge clk);
    fifo_rd_en = 1'b0;
  endtask

  task automatic wait_level(input int lvl, input int budget);
    int n = 0;
    while (fifo_level != lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_level", fifo_level, lvl);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    int base, n;
    rst = 1'b1; frame_start = 1'b0; fifo_rd_en = 1'b0; force_busy = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", ctl_rd_enable, 0);
    check("rst_wr_en", ctl_wr_enable, 0);
    check("rst_rd_addr", ctl_rd_addr, 0);
    check("rst_wr_addr", ctl_wr_addr, 0);
    check("rst_wr_data", ctl_wr_data, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_level", fifo_level, 0);
    check("rst_underflow", underflow, 0);

    // Pop on an empty FIFO right out of reset
    rst = 1'b0;
    fifo_rd_en = 1'b1;
    @(negedge clk);
    fifo_rd_en = 1'b0;
    check("underflow_set", underflow, 1);

    // Fill to full, then reads stop
    wait_level(DEPTH, 400);
    repeat (20) @(negedge clk);
    check("full_level", fifo_level, DEPTH);
    check("full_reads", rd_issues, DEPTH);

    pop_word("pop1");
    repeat (15) @(negedge clk);
    check("refill_one", rd_issues, DEPTH + 1);
    check("refill_level", fifo_level, DEPTH);

    // Controller busy while the arbiter sits in the issue state
    pop_word("pop_busy");
    base = rd_issues;
    force_busy = 1'b1;
    repeat (5) @(negedge clk);
    force_busy = 1'b0;
    check("rd_during_busy", rd_issues, base);
    repeat (10) @(negedge clk);
    check("rd_after_busy", rd_issues, base + 1);

    // Drain to the end of the frame
    for (int i = 0; i < 6; i++) begin
      pop_word("drain_a");
      repeat (8) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) pop_word("drain_b");
    repeat (30) @(negedge clk);
    check("frame_reads", rd_issues, FW);
    check("frame_idle_level", fifo_level, 8);

    // Restart with a pending write: reads win below half, write wins at half
    pulse_frame_start();
    check("restart_level", fifo_level, 0);
    wr_addr = 24'h00ABCD; wr_data = 16'hBEEF; wr_valid = 1'b1;
    wr_q.push_back({wr_addr, wr_data});
    base = rd_issues;
    n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wr_ready_seen", wr_ready, 1);
    check("wr_prio_level", fifo_level, DEPTH / 2);
    check("wr_prio_reads", rd_issues - base, DEPTH / 2);
    wr_valid = 1'b0;
    @(negedge clk);
    check("wr_ready_pulse", wr_ready, 0);
    repeat (6) @(negedge clk);
    check("wr_issued", wr_issues, 1);
    wait_level(DEPTH, 300);

    // Restart while a read is outstanding
    pop_word("pop_fs");
    n = 0;
    while (rd_timer != 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_rd_wait", rd_timer, 3);
    pulse_frame_start();
    check("fs_wait_level", fifo_level, 0);
    check("fs_wait_empty", fifo_empty, 1);

    // Restart in the same cycle the controller returns data
    base = rd_issues;
    n = 0;
    while (!(rd_issues > base && rd_timer == 1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_rd_ready", rd_timer, 1);
    pulse_frame_start();
    check("fs_ready_level", fifo_level, 0);

    // Simultaneous push and pop at level 3
    n = 0;
    while (!(fifo_level == 3 && rd_timer == 1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_lvl3", fifo_level, 3);
    pop_word("pop_lvl3");
    check("push_pop_level", fifo_level, 3);

    wait_level(DEPTH, 300);
    for (int i = 0; i < DEPTH; i++) pop_word("drain_c");
    repeat (10) @(negedge clk);
    check("underflow_sticky", underflow, 1);
    check("enable_while_busy", busy_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
